// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential MIPS DIV/DIVU unit.
package div_pkg;

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [W-1:0] DZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle between the pipeline (master) and the divider (slave).
interface div_seq_if #(
  parameter int unsigned W = 32
);

  logic         start;
  logic         is_signed;
  logic [W-1:0] sr;
  logic [W-1:0] tg;
  logic         busy;
  logic         done;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         dz;

  modport master (
    output start, is_signed, sr, tg,
    input  busy, done, lo, hi, dz
  );

  modport slave (
    input  start, is_signed, sr, tg,
    output busy, done, lo, hi, dz
  );

endinterface

// File: rtl/div_seq_sub.sv
// The existing W-bit subtractor: res = sr - tg - bin, CF = borrow out, OF = signed overflow.
module Sub #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] sr,
  input  logic [W-1:0] tg,
  input  logic         bin,
  output logic [W-1:0] res,
  output logic         CF,
  output logic         OF
);

  logic [W:0] diff;

  always_comb begin
    diff = {1'b0, sr} - {1'b0, tg} - {{W{1'b0}}, bin};
    res  = diff[W-1:0];
    CF   = diff[W];
    OF   = (sr[W-1] ^ tg[W-1]) & (sr[W-1] ^ diff[W-1]);
  end

endmodule

// File: rtl/div_seq.sv
// Restoring 32-bit divider for DIV/DIVU: one shared subtractor, 32 iterations,
// quotient to LO and remainder to HI with sign fix-up on the magnitudes.
module div_seq #(
  parameter int unsigned W     = div_pkg::W,
  parameter int unsigned CNT_W = div_pkg::CNT_W
) (
  input  logic     clk,
  input  logic     rst_n,
  div_seq_if.slave bus
);

  import div_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     sr_q, sr_d;
  logic [W-1:0]     tg_q, tg_d;
  logic             sgn_q, sgn_d;
  logic [W-1:0]     d_q, d_d;
  logic [W-1:0]     q_q, q_d;
  logic [W-1:0]     r_q, r_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [W-1:0]     hi_q, hi_d;
  logic             dz_q, dz_d;

  logic [W-1:0] s_val;
  logic [W-1:0] sub_res;
  logic         sub_cf;
  logic         sub_of_unused;
  logic         take;
  logic [W-1:0] abs_sr;
  logic [W-1:0] abs_tg;

  // Partial remainder shifted left with the next dividend bit; R[31] is the
  // bit pushed out, which forces the subtraction regardless of borrow.
  assign s_val = {r_q[W-2:0], q_q[W-1]};
  assign take  = r_q[W-1] | ~sub_cf;

  assign abs_sr = (sgn_q && sr_q[W-1]) ? (~sr_q + W'(1)) : sr_q;
  assign abs_tg = (sgn_q && tg_q[W-1]) ? (~tg_q + W'(1)) : tg_q;

  Sub #(.W(W)) u_sub (
    .sr  (s_val),
    .tg  (d_q),
    .bin (1'b0),
    .res (sub_res),
    .CF  (sub_cf),
    .OF  (sub_of_unused)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    tg_d    = tg_q;
    sgn_d   = sgn_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = bus.sr;
          tg_d    = bus.tg;
          sgn_d   = bus.is_signed;
          state_d = PREP;
        end
      end
      PREP: begin
        if (tg_q == '0) begin
          dz_d    = 1'b1;
          lo_d    = DZ_QUOT;
          hi_d    = sr_q;
          state_d = DONE;
        end else begin
          d_d     = abs_tg;
          q_d     = abs_sr;
          neg_q_d = sgn_q & (sr_q[W-1] ^ tg_q[W-1]);
          neg_r_d = sgn_q & sr_q[W-1];
          r_d     = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        if (take) begin
          r_d = sub_res;
          q_d = {q_q[W-2:0], 1'b1};
        end else begin
          r_d = s_val;
          q_d = {q_q[W-2:0], 1'b0};
        end
        if (cnt_q == CNT_W'(W-1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        lo_d    = neg_q_q ? (~q_q + W'(1)) : q_q;
        hi_d    = neg_r_q ? (~r_q + W'(1)) : r_q;
        dz_d    = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      tg_q    <= '0;
      sgn_q   <= 1'b0;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      tg_q    <= tg_d;
      sgn_q   <= sgn_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.lo   = lo_q;
  assign bus.hi   = hi_q;
  assign bus.dz   = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// Randomized and directed checks of div_seq against a plain-arithmetic division model.
module tb_div_seq;

  logic clk;
  logic rst_n;

  div_seq_if #(.W(32)) bus ();

  div_seq #(.W(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Quotient truncates toward zero, remainder follows the dividend (SV / and % on longint).
  task automatic ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output bit z);
    longint la, lb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      if (sgn) begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
      end else begin
        la = longint'({32'd0, a});
        lb = longint'({32'd0, b});
      end
      q = 32'(la / lb);
      r = 32'(la % lb);
      z = 1'b0;
    end
  endtask

  // mode 0: plain op; mode 1: start re-pulsed with other operands mid-ITER;
  // mode 2: reset asserted while cnt==10, no result expected.
  task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [31:0] eq, er;
    bit          ez;
    int          e;
    int          extra_done;
    ref_div(sgn, a, b, eq, er, ez);

    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.sr        = a;
    bus.tg        = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.sr    = $urandom;
    bus.tg    = $urandom;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);

    e = 0;
    while (e < 60) begin
      @(negedge clk);
      e++;
      if (mode == 1 && e == 10) begin
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.sr        = 32'd1;
        bus.tg        = 32'd1;
      end
      if (mode == 1 && e == 11) bus.start = 1'b0;
      if (mode == 2 && e == 11) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_dz", {31'd0, bus.dz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        repeat (40) begin
          @(negedge clk);
          if (bus.done) extra_done++;
        end
        check("rst_no_done", 32'(extra_done), 32'd0);
        return;
      end
      if (bus.done) break;
      check("busy_in_flight", {31'd0, bus.busy}, 32'd1);
    end

    if (ez) check("latency_dz", {31'd0, (e >= 1 && e <= 2)}, 32'd1);
    else    check("latency", 32'(e), 32'd34);
    check("done_busy", {31'd0, bus.busy}, 32'd1);
    check("lo", bus.lo, eq);
    check("hi", bus.hi, er);
    check("dz", {31'd0, bus.dz}, {31'd0, ez});

    @(negedge clk);
    check("done_pulse", {31'd0, bus.done}, 32'd0);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("lo_hold", bus.lo, eq);
    check("hi_hold", bus.hi, er);

    if (mode == 1) begin
      extra_done = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus.done) extra_done++;
      end
      check("single_done", 32'(extra_done), 32'd0);
      check("lo_after_repulse", bus.lo, eq);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    bit          sgn;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.sr        = '0;
    bus.tg        = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_dz", {31'd0, bus.dz}, 32'd0);
    rst_n = 1'b1;

    do_op(1'b0, 32'd100, 32'd7, 0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 32'd5, 32'd0, 0);
    do_op(1'b0, 32'd9, 32'd3, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 2);
    do_op(1'b0, 32'd100, 32'd7, 0);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    do_op(1'b1, 32'h8000_0000, 32'd0, 0);
    do_op(1'b0, 32'd3, 32'hFFFF_FFFF, 0);

    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      do_op(sgn, a, b, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
